trigger_capture: RTL and testbench
==================================

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 Parameter ADDR_W, default 10: sample-buffer address width; buffer depth is 2^ADDR_W.
REQ-002 Parameter AUTO_TIMEOUT, default 4096: decimated samples waited in WAIT_TRIG before a forced trigger.
REQ-003 Parameter HOLDOFF, default 1000: clk cycles spent in HOLD before re-arming.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 enable  input  1  run control; 1 = acquire continuously.
REQ-007 auto_mode  input  1  1 = forced trigger after AUTO_TIMEOUT.
REQ-008 adc_data  input  12  unsigned ADC sample.
REQ-009 adc_valid  input  1  adc_data is valid this cycle.
REQ-010 trigger  input  12  rising-edge trigger level from the user-interface stage.
REQ-011 trig_clk  input  12  decimation factor from the user-interface stage.
REQ-012 count_adc  input  12  capture length in samples from the user-interface stage.
REQ-013 wr_en  output  1  buffer write strobe.
REQ-014 wr_addr  output  ADDR_W  buffer write address.
REQ-015 wr_data  output  12  buffer write data.
REQ-016 frame_done  output  1  one-cycle pulse when a frame completes.
REQ-017 armed  output  1  high while in WAIT_TRIG.
REQ-018 forced  output  1  last frame was auto-triggered; held until the next frame starts.

Function
REQ-019 States: IDLE, ARM, WAIT_TRIG, CAPTURE, HOLD.
REQ-020 Transitions:
- IDLE->ARM when enable=1.
- ARM->WAIT_TRIG after exactly 1 cycle.
- WAIT_TRIG->CAPTURE on trigger event.
- CAPTURE->HOLD after the last write.
- HOLD->ARM after HOLDOFF cycles if enable=1; otherwise HOLD->IDLE.
REQ-021 In ARM, trigger, trig_clk and count_adc shall be latched; these latched values govern the whole frame.
REQ-022 Decimated strobe: asserted on every Nth adc_valid, N = latched trig_clk. trig_clk=0 shall be treated as 1. The decimation counter shall clear in ARM.
REQ-023 Trigger event: on a strobe in WAIT_TRIG, previous decimated sample < latched trigger and current sample >= latched trigger. The first strobe after ARM only loads the previous-sample register and shall never trigger.
REQ-024 The triggering sample shall be written at address 0 in the same cycle the state enters CAPTURE (wr_en=1 that cycle).
REQ-025 In CAPTURE, each strobe writes wr_data = sample to wr_addr and then increments wr_addr; wr_en is high only on strobe cycles.
REQ-026 Frame length L = latched count_adc. L=0 or L > 2^ADDR_W shall be clamped to 2^ADDR_W.
REQ-027 After the L-th write: frame_done=1 for 1 cycle (the cycle after that write), then state=HOLD. wr_addr shall never wrap within a frame.
REQ-028 Auto trigger: with auto_mode=1, the AUTO_TIMEOUT-th strobe in WAIT_TRIG without a trigger event forces CAPTURE; that sample is written at address 0 and forced=1.
REQ-029 enable=0 in ARM or WAIT_TRIG: go to IDLE next cycle with no writes. enable=0 in CAPTURE: finish the frame.
REQ-030 A trigger event and the timeout on the same strobe count as a real trigger (forced=0).
REQ-031 adc_valid cycles outside ARM/WAIT_TRIG/CAPTURE shall be ignored.

Reset
REQ-032 rst=0 asynchronously forces:
- state=IDLE;
- wr_en=0, wr_addr=0, wr_data=0, frame_done=0, armed=0, forced=0;
- all counters and latches cleared.
REQ-033 Reset mid-CAPTURE shall abort the frame with no frame_done; after release the block restarts from IDLE.

Verification
REQ-034 Ramp 0..4095, adc_valid every cycle, trig_clk=1, trigger=2000, count_adc=16 -> writes 2000..2015 at addresses 0..15, one frame_done, forced=0.
REQ-035 Same ramp, trig_clk=4 -> wr_en every 4th valid; written samples are spaced by 4.
REQ-036 Constant input 100, trigger=2000, auto_mode=1, AUTO_TIMEOUT=8 -> capture starts on the 8th strobe, forced=1; with auto_mode=0 -> no writes, armed stays 1.
REQ-037 count_adc=0 and count_adc=3000 -> exactly 1024 writes, last wr_addr=1023, no wrap.
REQ-038 Change trigger mid-frame -> frame uses the level latched in ARM.
REQ-039 enable=0 in WAIT_TRIG -> IDLE next cycle; rst=0 pulse mid-CAPTURE -> outputs at reset values immediately, no frame_done.

Source files
------------

// File: rtl/trigger_capture_if.sv
// trigger_capture_if: run control, ADC sample stream, frame settings and
// sample-buffer write port of trigger_capture.
interface trigger_capture_if #(parameter int ADDR_W = 10);
   logic              enable;
   logic              auto_mode;
   logic [11:0]       adc_data;
   logic              adc_valid;
   logic [11:0]       trigger;
   logic [11:0]       trig_clk;
   logic [11:0]       count_adc;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [11:0]       wr_data;
   logic              frame_done;
   logic              armed;
   logic              forced;
   modport master (
      output enable, auto_mode, adc_data, adc_valid, trigger, trig_clk, count_adc,
      input  wr_en, wr_addr, wr_data, frame_done, armed, forced
   );
   modport slave (
      input  enable, auto_mode, adc_data, adc_valid, trigger, trig_clk, count_adc,
      output wr_en, wr_addr, wr_data, frame_done, armed, forced
   );
endinterface

// File: rtl/trigger_capture.sv
// trigger_capture: decimates an ADC stream, waits for a rising-edge (or timed-out
// auto) trigger and writes one frame of samples into a buffer, then holds off.
module trigger_capture #(
   parameter int ADDR_W       = 10,
   parameter int AUTO_TIMEOUT = 4096,
   parameter int HOLDOFF      = 1000
) (
   input logic              clk,
   input logic              rst_n,
   trigger_capture_if.slave bus
);
   typedef enum logic [2:0] {IDLE, ARM, WAIT_TRIG, CAPTURE, HOLD} state_t;
   localparam int DEPTH = 1 << ADDR_W;
   localparam int LW    = ADDR_W + 1;
   localparam int TW    = $clog2(AUTO_TIMEOUT + 1);
   localparam int HW    = $clog2(HOLDOFF + 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(AUTO_TIMEOUT - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);
   state_t            state_q, state_d;
   logic [11:0]       trig_q, dec_last_q, dec_q, prev_q, wr_data_q;
   logic [LW-1:0]     len_q, n_q, len_in;
   logic [TW-1:0]     to_q;
   logic [HW-1:0]     hold_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic              prev_vld_q, wr_en_q, done_q, forced_q;
   logic              strobe, hit, timeout, fire, last;
   assign len_in  = (bus.count_adc == 12'd0 || int'(bus.count_adc) > DEPTH) ? LW'(DEPTH) : LW'(bus.count_adc);
   assign strobe  = (state_q == WAIT_TRIG || state_q == CAPTURE) && bus.adc_valid && dec_q == dec_last_q;
   assign hit     = strobe && prev_vld_q && prev_q < trig_q && bus.adc_data >= trig_q;
   assign timeout = strobe && bus.auto_mode && to_q == TO_LAST;
   assign fire    = state_q == WAIT_TRIG && bus.enable && (hit || timeout);
   // n_q counts writes already issued; the frame ends the cycle after the last one is on the bus
   assign last    = state_q == CAPTURE && n_q == len_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:      state_d = bus.enable ? ARM : IDLE;
         ARM:       state_d = bus.enable ? WAIT_TRIG : IDLE;
         WAIT_TRIG: state_d = !bus.enable ? IDLE : fire ? CAPTURE : WAIT_TRIG;
         CAPTURE:   state_d = last ? HOLD : CAPTURE;
         HOLD:      state_d = hold_q != HOLD_LAST ? HOLD : bus.enable ? ARM : IDLE;
         default:   state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         trig_q     <= '0;
         dec_last_q <= '0;
         len_q      <= '0;
         dec_q      <= '0;
         prev_q     <= '0;
         prev_vld_q <= 1'b0;
         to_q       <= '0;
         hold_q     <= '0;
         n_q        <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
         forced_q   <= 1'b0;
      end else begin
         wr_en_q <= 1'b0;
         done_q  <= last;
         hold_q  <= state_q == HOLD ? hold_q + HW'(1) : '0;
         if (state_q == ARM) begin
            trig_q     <= bus.trigger;
            dec_last_q <= bus.trig_clk == 12'd0 ? 12'd0 : bus.trig_clk - 12'd1;
            len_q      <= len_in;
            dec_q      <= '0;
            prev_vld_q <= 1'b0;
            to_q       <= '0;
         end
         if ((state_q == WAIT_TRIG || state_q == CAPTURE) && bus.adc_valid)
            dec_q <= strobe ? 12'd0 : dec_q + 12'd1;
         // timeout counter saturates so a late switch to auto_mode fires on the next strobe
         if (state_q == WAIT_TRIG && strobe) begin
            prev_q     <= bus.adc_data;
            prev_vld_q <= 1'b1;
            if (to_q != TO_LAST) to_q <= to_q + TW'(1);
         end
         if (fire) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= '0;
            wr_data_q <= bus.adc_data;
            n_q       <= LW'(1);
            forced_q  <= !hit;
         end
         if (state_q == CAPTURE && strobe && n_q != len_q) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= n_q[ADDR_W-1:0];
            wr_data_q <= bus.adc_data;
            n_q       <= n_q + LW'(1);
         end
      end
   always_comb begin
      bus.armed      = state_q == WAIT_TRIG;
      bus.wr_en      = wr_en_q;
      bus.wr_addr    = wr_addr_q;
      bus.wr_data    = wr_data_q;
      bus.frame_done = done_q;
      bus.forced     = forced_q;
   end
endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: randomized frames checked against a strobe-list model of
// trigger_capture, plus reset, auto, clamp and abort scenarios.
module tb_trigger_capture;
   localparam int ADDR_W = 10, AT = 8, HOLDOFF = 20, DEPTH = 1 << ADDR_W;
   logic clk = 1'b0, rst_n = 1'b1;
   int n_cmp = 0, n_bad = 0;
   int smp[$], exp_idx[$], obs_idx[$], obs_addr[$], obs_data[$];
   bit exp_forced, obs_forced, obs_stuck;
   int obs_done, obs_dly, obs_lost, obs_after;
   trigger_capture_if #(.ADDR_W(ADDR_W)) bus();
   trigger_capture #(.ADDR_W(ADDR_W), .AUTO_TIMEOUT(AT), .HOLDOFF(HOLDOFF)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );
   always #5 clk = ~clk;
   task automatic add_ramp(input int from, input int cnt);
      for (int i = 0; i < cnt; i++) smp.push_back((from + i) % 4096);
   endtask
   task automatic add_const(input int v, input int cnt);
      for (int i = 0; i < cnt; i++) smp.push_back(v);
   endtask
   task automatic add_walk(input int cnt);
      int v;
      v = int'($urandom_range(0, 4095));
      for (int i = 0; i < cnt; i++) begin
         v = v + int'($urandom_range(0, 600)) - 300;
         v = v < 0 ? 0 : v > 4095 ? 4095 : v;
         smp.push_back(v);
      end
   endtask
   // Strobe k is the (k+1)*n-th valid sample; the frame is L consecutive strobes from the trigger
   task automatic model(input int tclk, input int trg, input int cnt, input bit aut);
      int n, len, ns, st;
      bit h;
      n = tclk == 0 ? 1 : tclk;
      len = (cnt == 0 || cnt > DEPTH) ? DEPTH : cnt;
      ns = smp.size() / n;
      st = -1;
      exp_idx = {};
      exp_forced = 1'b0;
      for (int k = 0; k < ns && st < 0; k++) begin
         h = k > 0 && smp[k*n-1] < trg && smp[(k+1)*n-1] >= trg;
         if (h || (aut && k == AT - 1)) begin
            st = k;
            exp_forced = !h;
         end
      end
      if (st >= 0)
         for (int j = 0; j < len && st + j < ns; j++) exp_idx.push_back((st + j + 1) * n - 1);
   endtask
   task automatic frame_scenario(input string name, input int tclk, input int trg, input int cnt,
                                 input bit aut, input int gap);
      int i, tag, c, drain, guard, m;
      bit wrote;
      model(tclk, trg, cnt, aut);
      obs_idx = {}; obs_addr = {}; obs_data = {};
      obs_done = 0; obs_dly = -1; obs_lost = 0; obs_after = -1; obs_stuck = 0;
      wrote = 0; i = 0; tag = -1; c = 0; drain = 0;
      @(negedge clk);
      bus.trigger = 12'(trg); bus.trig_clk = 12'(tclk); bus.count_adc = 12'(cnt);
      bus.auto_mode = aut; bus.adc_valid = 1'b0; bus.enable = 1'b1;
      for (int k = 1; k <= 10 && obs_dly < 0; k++) begin
         @(negedge clk);
         if (bus.armed) obs_dly = k;
      end
      guard = 4 * smp.size() + HOLDOFF + 100;
      while (obs_dly >= 0 && (i < smp.size() || tag >= 0 || (wrote && drain < HOLDOFF + 5))) begin
         if (bus.wr_en) begin
            obs_idx.push_back(tag);
            obs_addr.push_back(int'(bus.wr_addr));
            obs_data.push_back(int'(bus.wr_data));
            wrote = 1;
         end else if (!wrote && !bus.armed) obs_lost++;
         if (bus.frame_done) obs_done++;
         if (i >= smp.size()) drain++;
         // settings move freely after ARM; the frame must keep the latched ones
         bus.trigger = 12'($urandom); bus.trig_clk = 12'($urandom); bus.count_adc = 12'($urandom);
         bus.enable = !wrote;
         if (i < smp.size() && int'($urandom_range(0, 99)) >= gap) begin
            bus.adc_valid = 1'b1; bus.adc_data = 12'(smp[i]); tag = i; i++;
         end else begin
            bus.adc_valid = 1'b0; bus.adc_data = 12'($urandom); tag = -1;
         end
         @(negedge clk);
         c++;
         if (c > guard) begin
            obs_stuck = 1;
            break;
         end
      end
      bus.adc_valid = 1'b0;
      if (!wrote && obs_dly >= 0) begin
         bus.enable = 1'b0;
         @(negedge clk);
         obs_after = int'(bus.armed);
      end
      bus.enable = 1'b0;
      obs_forced = bus.forced;
      if (obs_dly < 0 || obs_stuck) repeat (HOLDOFF + 10) @(negedge clk);
      n_cmp++;
      if (obs_dly !== 2) begin n_bad++; $display("FAIL %s arm_delay: got %0d want 2", name, obs_dly); end
      n_cmp++;
      if (obs_stuck) begin n_bad++; $display("FAIL %s cycle_budget: got expired want finished", name); end
      n_cmp++;
      if (obs_idx.size() !== exp_idx.size()) begin
         n_bad++; $display("FAIL %s write_count: got %0d want %0d", name, obs_idx.size(), exp_idx.size());
      end
      m = obs_idx.size() < exp_idx.size() ? obs_idx.size() : exp_idx.size();
      for (int j = 0; j < m; j++) begin
         n_cmp++;
         if (obs_idx[j] !== exp_idx[j] || obs_addr[j] !== j || obs_data[j] !== smp[exp_idx[j]]) begin
            n_bad++;
            $display("FAIL %s write%0d: got sample#%0d addr %0d data %0d want sample#%0d addr %0d data %0d",
                     name, j, obs_idx[j], obs_addr[j], obs_data[j], exp_idx[j], j, smp[exp_idx[j]]);
         end
      end
      n_cmp++;
      if (obs_done !== (exp_idx.size() > 0 ? 1 : 0)) begin
         n_bad++; $display("FAIL %s frame_done_count: got %0d want %0d", name, obs_done, exp_idx.size() > 0);
      end
      if (exp_idx.size() > 0) begin
         n_cmp++;
         if (obs_forced !== exp_forced) begin
            n_bad++; $display("FAIL %s forced: got %0d want %0d", name, obs_forced, exp_forced);
         end
      end else begin
         n_cmp++;
         if (obs_lost !== 0) begin n_bad++; $display("FAIL %s armed_drops: got %0d want 0", name, obs_lost); end
         n_cmp++;
         if (obs_after !== 0) begin n_bad++; $display("FAIL %s armed_after_disable: got %0d want 0", name, obs_after); end
      end
   endtask
   task automatic test_reset();
      int seen;
      bus.enable = 1'b0; bus.auto_mode = 1'b0; bus.adc_valid = 1'b0; bus.adc_data = '0;
      bus.trigger = '0; bus.trig_clk = '0; bus.count_adc = '0;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL reset wr_en: got %b want 0", bus.wr_en); end
      n_cmp++; if (bus.wr_addr !== '0) begin n_bad++; $display("FAIL reset wr_addr: got %0d want 0", bus.wr_addr); end
      n_cmp++; if (bus.wr_data !== '0) begin n_bad++; $display("FAIL reset wr_data: got %0d want 0", bus.wr_data); end
      n_cmp++; if (bus.frame_done !== 1'b0) begin n_bad++; $display("FAIL reset frame_done: got %b want 0", bus.frame_done); end
      n_cmp++; if (bus.armed !== 1'b0) begin n_bad++; $display("FAIL reset armed: got %b want 0", bus.armed); end
      n_cmp++; if (bus.forced !== 1'b0) begin n_bad++; $display("FAIL reset forced: got %b want 0", bus.forced); end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (5) begin @(negedge clk); seen += int'(bus.armed) + int'(bus.wr_en); end
      n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL idle_hold activity: got %0d want 0", seen); end
   endtask
   task automatic test_ramp();
      smp = {}; add_ramp(0, 2200);
      frame_scenario("ramp", 1, 2000, 16, 1'b0, 0);
      n_cmp++;
      if (obs_data.size() !== 16 || obs_data[0] !== 2000 || obs_data[obs_data.size()-1] !== 2015) begin
         n_bad++; $display("FAIL ramp span: got %0d writes want 16 writes 2000..2015", obs_data.size());
      end
   endtask
   task automatic test_decimation();
      int bad;
      smp = {}; add_ramp(0, 2400);
      frame_scenario("decim", 4, 2000, 12, 1'b0, 30);
      bad = 0;
      for (int j = 1; j < obs_data.size(); j++) if (obs_data[j] - obs_data[j-1] != 4) bad++;
      n_cmp++;
      if (bad !== 0 || obs_data.size() !== 12) begin
         n_bad++; $display("FAIL decim spacing: got %0d bad steps in %0d writes want 0 in 12", bad, obs_data.size());
      end
   endtask
   task automatic test_auto();
      smp = {}; add_const(100, 30);
      frame_scenario("auto_on", 1, 2000, 5, 1'b1, 0);
      n_cmp++;
      if (obs_forced !== 1'b1 || obs_idx.size() == 0 || obs_idx[0] !== AT - 1) begin
         n_bad++; $display("FAIL auto_start: got forced %0d first sample#%0d want forced 1 sample#%0d",
                           obs_forced, obs_idx.size() ? obs_idx[0] : -1, AT - 1);
      end
      smp = {}; add_const(100, 30);
      frame_scenario("auto_off", 1, 2000, 5, 1'b0, 0);
      n_cmp++;
      if (obs_idx.size() !== 0) begin n_bad++; $display("FAIL auto_off writes: got %0d want 0", obs_idx.size()); end
   endtask
   task automatic test_clamp();
      int cnts[2];
      cnts[0] = 0; cnts[1] = 3000;
      foreach (cnts[k]) begin
         smp = {}; add_ramp(0, 200); add_const(0, 1100);
         frame_scenario("clamp", 1, 50, cnts[k], 1'b0, 0);
         n_cmp++;
         if (obs_addr.size() !== DEPTH || obs_addr[obs_addr.size()-1] !== DEPTH - 1) begin
            n_bad++; $display("FAIL clamp count_adc=%0d: got %0d writes want %0d ending at %0d",
                              cnts[k], obs_addr.size(), DEPTH, DEPTH - 1);
         end
      end
   endtask
   task automatic test_reset_mid();
      int seen, i, act;
      smp = {}; add_ramp(0, 400);
      @(negedge clk);
      bus.trigger = 12'd100; bus.trig_clk = 12'd1; bus.count_adc = 12'd200;
      bus.auto_mode = 1'b0; bus.adc_valid = 1'b0; bus.enable = 1'b1;
      for (int k = 0; k < 10 && !bus.armed; k++) @(negedge clk);
      seen = 0; i = 0;
      while (seen < 5 && i < smp.size()) begin
         bus.adc_valid = 1'b1; bus.adc_data = 12'(smp[i]); i++;
         @(negedge clk);
         if (bus.wr_en) seen++;
      end
      n_cmp++;
      if (seen !== 5) begin n_bad++; $display("FAIL abort precondition writes: got %0d want 5", seen); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.wr_en !== 1'b0) begin n_bad++; $display("FAIL abort wr_en: got %b want 0", bus.wr_en); end
      n_cmp++; if (bus.wr_addr !== '0) begin n_bad++; $display("FAIL abort wr_addr: got %0d want 0", bus.wr_addr); end
      n_cmp++; if (bus.wr_data !== '0) begin n_bad++; $display("FAIL abort wr_data: got %0d want 0", bus.wr_data); end
      bus.enable = 1'b0; bus.adc_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      act = 0;
      repeat (30) begin @(negedge clk); act += int'(bus.frame_done) + int'(bus.wr_en) + int'(bus.armed); end
      n_cmp++;
      if (act !== 0) begin n_bad++; $display("FAIL abort after_release activity: got %0d want 0", act); end
   endtask
   task automatic test_random();
      int tclk, eff, trg, cnt, len;
      bit aut;
      for (int f = 0; f < 8; f++) begin
         tclk = int'($urandom_range(0, 5));
         eff = tclk == 0 ? 1 : tclk;
         trg = int'($urandom_range(200, 3800));
         cnt = $urandom_range(0, 9) == 0 ? 0 : int'($urandom_range(1, 40));
         len = cnt == 0 ? DEPTH : cnt;
         aut = 1'($urandom_range(0, 1));
         smp = {};
         add_walk(eff * (AT + 2) + int'($urandom_range(0, 80)));
         add_const(0, eff * (len + 2));
         frame_scenario($sformatf("random%0d", f), tclk, trg, cnt, aut, int'($urandom_range(0, 50)));
      end
   endtask
   initial begin
      test_reset();
      test_ramp();
      test_decimation();
      test_auto();
      test_clamp();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
